// File: rtl/gpu_pkg.sv
// Core-wide scheduler state codes, register-write source encodings and read-only register indices.
// Pure definitions: no latency and no backpressure.
package gpu_pkg;

    localparam logic [2:0] CORE_IDLE    = 3'b000;
    localparam logic [2:0] CORE_FETCH   = 3'b001;
    localparam logic [2:0] CORE_DECODE  = 3'b010;
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_WAIT    = 3'b100;
    localparam logic [2:0] CORE_EXECUTE = 3'b101;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;
    localparam logic [2:0] CORE_DONE    = 3'b111;

    localparam logic [1:0] MUX_ARITHMETIC = 2'b00;
    localparam logic [1:0] MUX_MEMORY     = 2'b01;
    localparam logic [1:0] MUX_CONSTANT   = 2'b10;
    localparam logic [1:0] MUX_RESERVED   = 2'b11;

    // The three read-only registers occupy the top of each lane's register space.
    function automatic int ro_block_idx(input int num_regs);
        return num_regs - 3;
    endfunction

    function automatic int ro_block_dim(input int num_regs);
        return num_regs - 2;
    endfunction

    function automatic int ro_thread_idx(input int num_regs);
        return num_regs - 1;
    endfunction

endpackage

// File: rtl/core_regfile_if.sv
// Decoder/scheduler to register-file bus; the master drives decode and results, the slave returns operands.
// Operands arrive 1 cycle after REQUEST; there is no backpressure.
interface core_regfile_if #(
    parameter int THREADS       = 4,
    parameter int DATA_BITS     = 8,
    parameter int NUM_REGS      = 16,
    parameter int BLOCK_ID_BITS = 8
);
    logic                           block_start;
    logic [BLOCK_ID_BITS-1:0]       block_id;
    logic [$clog2(THREADS):0]       thread_count;
    logic [2:0]                     core_state;
    logic [$clog2(NUM_REGS)-1:0]    rd_addr;
    logic [$clog2(NUM_REGS)-1:0]    rs_addr;
    logic [$clog2(NUM_REGS)-1:0]    rt_addr;
    logic                           reg_write_enable;
    logic [1:0]                     reg_input_mux;
    logic [DATA_BITS-1:0]           immediate;
    logic [THREADS*DATA_BITS-1:0]   alu_out;
    logic [THREADS*DATA_BITS-1:0]   lsu_out;
    logic [THREADS*DATA_BITS-1:0]   rs_out;
    logic [THREADS*DATA_BITS-1:0]   rt_out;
    logic                           operand_valid;
    logic                           illegal_write;

    modport master (
        output block_start, block_id, thread_count, core_state,
        output rd_addr, rs_addr, rt_addr, reg_write_enable, reg_input_mux,
        output immediate, alu_out, lsu_out,
        input  rs_out, rt_out, operand_valid, illegal_write
    );

    modport slave (
        input  block_start, block_id, thread_count, core_state,
        input  rd_addr, rs_addr, rt_addr, reg_write_enable, reg_input_mux,
        input  immediate, alu_out, lsu_out,
        output rs_out, rt_out, operand_valid, illegal_write
    );

endinterface

// File: rtl/regfile_lane.sv
// One thread lane's registers, operand capture and write-source mux.
// Read latency 1 cycle; no backpressure (enable simply freezes the lane).
module regfile_lane
    import gpu_pkg::*;
#(
    parameter int LANE      = 0,
    parameter int THREADS   = 4,
    parameter int DATA_BITS = 8,
    parameter int NUM_REGS  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        block_load,
    input  logic [DATA_BITS-1:0]        block_idx_val,
    input  logic [DATA_BITS-1:0]        block_dim_val,
    input  logic                        read_en,
    input  logic [$clog2(NUM_REGS)-1:0] rs_addr,
    input  logic [$clog2(NUM_REGS)-1:0] rt_addr,
    input  logic                        write_en,
    input  logic [$clog2(NUM_REGS)-1:0] rd_addr,
    input  logic [1:0]                  reg_input_mux,
    input  logic [DATA_BITS-1:0]        immediate,
    input  logic [DATA_BITS-1:0]        alu_val,
    input  logic [DATA_BITS-1:0]        lsu_val,
    output logic [DATA_BITS-1:0]        rs_val,
    output logic [DATA_BITS-1:0]        rt_val
);
    localparam int BLOCK_IDX  = ro_block_idx(NUM_REGS);
    localparam int BLOCK_DIM  = ro_block_dim(NUM_REGS);
    localparam int THREAD_IDX = ro_thread_idx(NUM_REGS);

    logic [DATA_BITS-1:0] regs [NUM_REGS];
    logic [DATA_BITS-1:0] wdata;

    always_comb begin
        wdata = immediate;
        case (reg_input_mux)
            MUX_ARITHMETIC: wdata = alu_val;
            MUX_MEMORY:     wdata = lsu_val;
            default:        wdata = immediate;
        endcase
    end

    // write_en is only raised for free-register targets, so it never collides with the block loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
            regs[BLOCK_DIM]  <= DATA_BITS'(THREADS);
            regs[THREAD_IDX] <= DATA_BITS'(LANE);
            rs_val <= '0;
            rt_val <= '0;
        end else begin
            if (write_en && enable) regs[rd_addr] <= wdata;
            if (block_load) begin
                regs[BLOCK_IDX] <= block_idx_val;
                regs[BLOCK_DIM] <= block_dim_val;
            end
            if (read_en && enable) begin
                rs_val <= regs[rs_addr];
                rt_val <= regs[rt_addr];
            end
        end
    end

endmodule

// File: rtl/core_regfile.sv
// Unified register file for all lanes of a core: block latching, lane mask, operand strobe, sticky error.
// Operand latency 1 cycle after REQUEST; no backpressure.
module core_regfile
    import gpu_pkg::*;
#(
    parameter int THREADS       = 4,
    parameter int DATA_BITS     = 8,
    parameter int NUM_REGS      = 16,
    parameter int BLOCK_ID_BITS = 8
) (
    input  logic       clk,
    input  logic       reset,
    core_regfile_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int TW = $clog2(THREADS) + 1;

    logic [TW-1:0]                count_q;
    logic [THREADS-1:0]           lane_en;
    logic                         read_req;
    logic                         write_req;
    logic                         bad_write;
    logic                         good_write;
    logic                         operand_valid_q;
    logic                         illegal_write_q;
    logic [THREADS*DATA_BITS-1:0] rs_bus;
    logic [THREADS*DATA_BITS-1:0] rt_bus;

    always_comb begin
        read_req   = (bus.core_state == CORE_REQUEST);
        write_req  = (bus.core_state == CORE_UPDATE) && bus.reg_write_enable;
        bad_write  = write_req && ((bus.rd_addr >= AW'(ro_block_idx(NUM_REGS)))
                                   || (bus.reg_input_mux == MUX_RESERVED));
        good_write = write_req && !bad_write;
        for (int i = 0; i < THREADS; i++) lane_en[i] = (count_q > TW'(i));
    end

    // The new thread count masks lanes only from the edge after block_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q         <= TW'(THREADS);
            operand_valid_q <= 1'b0;
            illegal_write_q <= 1'b0;
        end else begin
            if (bus.block_start) count_q <= bus.thread_count;
            operand_valid_q <= read_req;
            if (bad_write) illegal_write_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < THREADS; i++) begin : g_lane
        regfile_lane #(
            .LANE      (i),
            .THREADS   (THREADS),
            .DATA_BITS (DATA_BITS),
            .NUM_REGS  (NUM_REGS)
        ) u_lane (
            .clk           (clk),
            .reset         (reset),
            .enable        (lane_en[i]),
            .block_load    (bus.block_start),
            .block_idx_val (DATA_BITS'(bus.block_id)),
            .block_dim_val (DATA_BITS'(bus.thread_count)),
            .read_en       (read_req),
            .rs_addr       (bus.rs_addr),
            .rt_addr       (bus.rt_addr),
            .write_en      (good_write),
            .rd_addr       (bus.rd_addr),
            .reg_input_mux (bus.reg_input_mux),
            .immediate     (bus.immediate),
            .alu_val       (bus.alu_out[i*DATA_BITS +: DATA_BITS]),
            .lsu_val       (bus.lsu_out[i*DATA_BITS +: DATA_BITS]),
            .rs_val        (rs_bus[i*DATA_BITS +: DATA_BITS]),
            .rt_val        (rt_bus[i*DATA_BITS +: DATA_BITS])
        );
    end

    assign bus.rs_out        = rs_bus;
    assign bus.rt_out        = rt_bus;
    assign bus.operand_valid = operand_valid_q;
    assign bus.illegal_write = illegal_write_q;

endmodule

// File: tb/tb_core_regfile.sv
// Directed plus randomized bench for core_regfile against an array-based model of the register rules.
module tb_core_regfile;
    localparam int THREADS       = 4;
    localparam int DATA_BITS     = 8;
    localparam int NUM_REGS      = 16;
    localparam int BLOCK_ID_BITS = 8;
    localparam int BI = NUM_REGS - 3;
    localparam int BD = NUM_REGS - 2;
    localparam int TI = NUM_REGS - 1;
    localparam logic [2:0] ST_IDLE = 3'b000, ST_REQ = 3'b011, ST_UPD = 3'b110;

    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    core_regfile_if #(.THREADS(THREADS), .DATA_BITS(DATA_BITS), .NUM_REGS(NUM_REGS),
                      .BLOCK_ID_BITS(BLOCK_ID_BITS)) bus ();

    core_regfile #(.THREADS(THREADS), .DATA_BITS(DATA_BITS), .NUM_REGS(NUM_REGS),
                   .BLOCK_ID_BITS(BLOCK_ID_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int m_reg [THREADS][NUM_REGS];
    int m_rs  [THREADS];
    int m_rt  [THREADS];
    int m_valid, m_ill, m_count;
    int compared = 0;
    int mismatched = 0;
    bit chk_en = 0;

    task automatic cmp(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rs_lane(input int l);
        return int'(bus.rs_out[l*DATA_BITS +: DATA_BITS]);
    endfunction

    function automatic int rt_lane(input int l);
        return int'(bus.rt_out[l*DATA_BITS +: DATA_BITS]);
    endfunction

    task automatic model_reset();
        for (int l = 0; l < THREADS; l++) begin
            for (int r = 0; r < NUM_REGS; r++) m_reg[l][r] = 0;
            m_reg[l][BD] = THREADS;
            m_reg[l][TI] = l;
            m_rs[l] = 0;
            m_rt[l] = 0;
        end
        m_valid = 0;
        m_ill   = 0;
        m_count = THREADS;
    endtask

    // Applies one clock edge's worth of architectural rules to the model, using the driven inputs.
    task automatic model_edge();
        int st, rd, val;
        if (reset) begin
            model_reset();
            return;
        end
        st = int'(bus.core_state);
        rd = int'(bus.rd_addr);
        m_valid = (st == 3) ? 1 : 0;
        if (st == 3) begin
            for (int l = 0; l < m_count; l++) begin
                m_rs[l] = m_reg[l][bus.rs_addr];
                m_rt[l] = m_reg[l][bus.rt_addr];
            end
        end
        if (st == 6 && bus.reg_write_enable) begin
            if (rd >= BI || bus.reg_input_mux == 2'b11) m_ill = 1;
            else begin
                for (int l = 0; l < m_count; l++) begin
                    if (bus.reg_input_mux == 2'b00)      val = int'(bus.alu_out[l*DATA_BITS +: DATA_BITS]);
                    else if (bus.reg_input_mux == 2'b01) val = int'(bus.lsu_out[l*DATA_BITS +: DATA_BITS]);
                    else                                 val = int'(bus.immediate);
                    m_reg[l][rd] = val;
                end
            end
        end
        if (bus.block_start) begin
            for (int l = 0; l < THREADS; l++) begin
                m_reg[l][BI] = int'(bus.block_id) % 256;
                m_reg[l][BD] = int'(bus.thread_count);
            end
            m_count = int'(bus.thread_count);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int l = 0; l < THREADS; l++) begin
                cmp($sformatf("model rs_out lane%0d", l), rs_lane(l), m_rs[l]);
                cmp($sformatf("model rt_out lane%0d", l), rt_lane(l), m_rt[l]);
            end
            cmp("model operand_valid", int'(bus.operand_valid), m_valid);
            cmp("model illegal_write", int'(bus.illegal_write), m_ill);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.core_state       = ST_IDLE;
        bus.reg_write_enable = 1'b0;
        bus.block_start      = 1'b0;
    endtask

    task automatic req(input int rs, input int rt);
        idle();
        bus.core_state = ST_REQ;
        bus.rs_addr    = 4'(rs);
        bus.rt_addr    = 4'(rt);
        tick();
    endtask

    task automatic upd(input int rd, input logic [1:0] mux, input int imm);
        idle();
        bus.core_state       = ST_UPD;
        bus.reg_write_enable = 1'b1;
        bus.rd_addr          = 4'(rd);
        bus.reg_input_mux    = mux;
        bus.immediate        = 8'(imm);
        tick();
    endtask

    task automatic blk(input int id, input int tc);
        idle();
        bus.block_start  = 1'b1;
        bus.block_id     = 8'(id);
        bus.thread_count = 3'(tc);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        bus.block_id = '0; bus.thread_count = '0;
        bus.rd_addr = '0; bus.rs_addr = '0; bus.rt_addr = '0;
        bus.reg_input_mux = '0; bus.immediate = '0;
        bus.alu_out = '0; bus.lsu_out = '0;
        @(negedge clk);
        tick();
        tick();
        chk_en = 1;
        reset  = 1'b0;

        // Reset values of the read-only registers, and strobe timing.
        req(13, 15);
        for (int l = 0; l < THREADS; l++) begin
            cmp($sformatf("reset blockIdx lane%0d", l), rs_lane(l), 0);
            cmp($sformatf("reset threadIdx lane%0d", l), rt_lane(l), l);
        end
        cmp("valid after request", int'(bus.operand_valid), 1);
        idle(); tick();
        cmp("valid one cycle only", int'(bus.operand_valid), 0);
        req(14, 14);
        for (int l = 0; l < THREADS; l++) cmp($sformatf("reset blockDim lane%0d", l), rs_lane(l), 4);

        // Block latch with a partial block.
        blk(8'h2A, 2);
        req(13, 14);
        for (int l = 0; l < 2; l++) begin
            cmp($sformatf("blockIdx lane%0d", l), rs_lane(l), 8'h2A);
            cmp($sformatf("blockDim lane%0d", l), rt_lane(l), 2);
        end
        for (int l = 2; l < THREADS; l++) cmp($sformatf("masked rs hold lane%0d", l), rs_lane(l), 4);

        // Write mux sources.
        blk(8'h2A, 4);
        bus.alu_out = 32'h40302010;
        bus.lsu_out = 32'hA3A2A1A0;
        upd(5, 2'b00, 0);
        upd(6, 2'b10, 8'h7F);
        upd(7, 2'b01, 0);
        req(5, 6);
        for (int l = 0; l < THREADS; l++) begin
            cmp($sformatf("alu R5 lane%0d", l), rs_lane(l), 16 * (l + 1));
            cmp($sformatf("const R6 lane%0d", l), rt_lane(l), 8'h7F);
        end
        req(7, 7);
        for (int l = 0; l < THREADS; l++) cmp($sformatf("lsu R7 lane%0d", l), rs_lane(l), 8'hA0 + l);

        // Illegal write to a read-only register is dropped and the flag sticks.
        upd(14, 2'b10, 8'h11);
        cmp("illegal set", int'(bus.illegal_write), 1);
        idle();
        repeat (10) tick();
        cmp("illegal sticky", int'(bus.illegal_write), 1);
        req(14, 14);
        cmp("R14 unchanged", rs_lane(0), 4);

        // Single-lane block: only lane 0 writes and reads.
        blk(8'h2A, 1);
        upd(3, 2'b10, 8'h55);
        req(3, 3);
        cmp("masked write lane0", rs_lane(0), 8'h55);
        for (int l = 1; l < THREADS; l++) cmp($sformatf("masked read hold lane%0d", l), rs_lane(l), 4);
        blk(8'h2A, 4);
        req(3, 3);
        for (int l = 1; l < THREADS; l++) cmp($sformatf("masked R3 kept lane%0d", l), rs_lane(l), 0);

        // Reset during a pending write wins.
        reset = 1'b1;
        upd(6, 2'b10, 8'h99);
        reset = 1'b0;
        cmp("illegal cleared by reset", int'(bus.illegal_write), 0);
        req(6, 15);
        for (int l = 0; l < THREADS; l++) begin
            cmp($sformatf("R6 after reset lane%0d", l), rs_lane(l), 0);
            cmp($sformatf("threadIdx after reset lane%0d", l), rt_lane(l), l);
        end

        // Randomized traffic; the compare process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            int r;
            idle();
            reset = ($urandom_range(0, 149) == 0);
            r = $urandom_range(0, 9);
            if (r < 4)      bus.core_state = ST_REQ;
            else if (r < 7) bus.core_state = ST_UPD;
            else            bus.core_state = 3'($urandom_range(0, 7));
            bus.reg_write_enable = ($urandom_range(0, 3) != 0);
            bus.rd_addr   = 4'($urandom_range(0, NUM_REGS - 1));
            bus.rs_addr   = 4'($urandom_range(0, NUM_REGS - 1));
            bus.rt_addr   = 4'($urandom_range(0, NUM_REGS - 1));
            r = $urandom_range(0, 19);
            bus.reg_input_mux = (r == 0) ? 2'b11 : 2'(r % 3);
            bus.immediate = 8'($urandom);
            bus.alu_out   = 32'($urandom);
            bus.lsu_out   = 32'($urandom);
            bus.block_start  = ($urandom_range(0, 15) == 0);
            bus.block_id     = 8'($urandom);
            bus.thread_count = 3'($urandom_range(0, THREADS));
            tick();
        end
        reset = 1'b0;
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/core_regfile.md
Name: core_regfile

Overview:
- Unified, parametrised register file for all thread lanes of one compute core. Replaces the per-thread register instances.
- Each lane holds NUM_REGS registers: free registers R0..R(NUM_REGS-4) plus three read-only registers %blockIdx, %blockDim and %threadIdx at the top three indices.
- Adds the following over the previous generation:
  - block-level latching of block ID and actual thread count;
  - per-lane enable mask;
  - an rs/rt valid strobe;
  - a sticky illegal-write flag.
- Sits between decoder/scheduler and the per-lane ALU/LSU.

Parameters:
- THREADS, 4, number of thread lanes per core.
- DATA_BITS, 8, register width.
- NUM_REGS, 16, registers per lane; must be a power of two and at least 4.
- BLOCK_ID_BITS, 8, width of the dispatched block ID.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- block_start  in  1  one-cycle pulse when the dispatcher issues a new block.
- block_id  in  BLOCK_ID_BITS  block ID; sampled on block_start.
- thread_count  in  $clog2(THREADS)+1  active threads in the new block; sampled on block_start.
- core_state  in  3  scheduler state; REQUEST=3'b011, UPDATE=3'b110.
- rd_addr, rs_addr, rt_addr  in  $clog2(NUM_REGS) each  decoded register addresses.
- reg_write_enable  in  1  decoded write enable.
- reg_input_mux  in  2  ARITHMETIC=00, MEMORY=01, CONSTANT=10, 11 reserved.
- immediate  in  DATA_BITS  decoded constant.
- alu_out  in  THREADS*DATA_BITS  per-lane ALU result; lane i is at bits [i*DATA_BITS +: DATA_BITS].
- lsu_out  in  THREADS*DATA_BITS  per-lane load data.
- rs_out, rt_out  out  THREADS*DATA_BITS  per-lane registered operands.
- operand_valid  out  1  one-cycle strobe: rs/rt were updated.
- illegal_write  out  1  sticky error flag.

Behaviour:
- Lane enable: lane i is active iff i < latched thread_count. Inactive lanes never change registers or rs/rt.
- Reset (wins over everything, including mid-block):
  - all free registers = 0;
  - %blockIdx = 0, %blockDim = THREADS, %threadIdx = lane index;
  - rs_out, rt_out = 0; operand_valid = 0; illegal_write = 0;
  - latched thread_count = THREADS, so all lanes are enabled.
- block_start:
  - the next edge loads %blockIdx of every lane with block_id, zero-extended or truncated to DATA_BITS;
  - the same edge loads %blockDim with thread_count, and latches thread_count into the lane mask;
  - %blockIdx is not rewritten on other cycles.
- REQUEST: the next edge loads rs_out/rt_out of each active lane from its registers[rs_addr]/[rt_addr]. operand_valid is 1 for exactly the cycle after the REQUEST cycle. Read latency is 1 cycle.
- UPDATE with reg_write_enable=1 and rd_addr < NUM_REGS-3: each active lane writes on the next edge:
  - ARITHMETIC: its alu_out slice;
  - MEMORY: its lsu_out slice;
  - CONSTANT: immediate, identical for all lanes;
  - 11: no write, and illegal_write is set.
- UPDATE with reg_write_enable=1 and rd_addr >= NUM_REGS-3: no write occurs and illegal_write is set. It stays set until reset.
- Simultaneous events:
  - block_start coinciding with an UPDATE write: both take effect. Free-register writes and the read-only loads never target the same index.
  - The lane mask change takes effect on the edge after that one. The coincident write uses the old mask.
  - REQUEST reads are pre-edge values; there is no write bypass, and the core states are exclusive anyway.
- Other core_state values: no register or operand change; operand_valid = 0.

Decomposition:
- Shared package gpu_pkg holds:
  - core_state localparams (IDLE..DONE, including REQUEST=3'b011 and UPDATE=3'b110);
  - the reg_input_mux encodings;
  - functions giving the RO register indices from NUM_REGS.
- One sub-module, regfile_lane: a single lane's storage, read capture and write mux, instantiated THREADS times through a generate loop. The top level handles latching, the lane mask and the error flag.

Test Plan:
- Reset check:
  - after reset, REQUEST with rs=13, rt=15 on lanes 0..3 -> rs_out lanes = 0, rt_out lanes = 0,1,2,3;
  - %blockDim read = 4;
  - operand_valid high exactly 1 cycle after REQUEST.
- Block latch: block_start with block_id=0x2A, thread_count=2, then REQUEST rs=13, rt=14 -> lanes 0,1 return 0x2A and 2. Lanes 2,3 hold their previous rs/rt.
- Write mux, with alu_out = {0x40,0x30,0x20,0x10} (lane 3 first):
  - ARITHMETIC UPDATE rd=5 -> R5 per lane = 0x10, 0x20, 0x30, 0x40;
  - CONSTANT 0x7F to rd=6 -> all lanes R6 = 0x7F;
  - MEMORY writes to rd=7 return the per-lane lsu_out slices.
- Illegal write: UPDATE writing rd=14 -> R14 unchanged and illegal_write=1. The flag persists over 10 later cycles and clears only on reset.
- Lane masking: thread_count=1, then CONSTANT 0x55 to R3 -> only lane 0 R3 = 0x55; lanes 1..3 keep their old R3.
- Reset mid-block: after writes, assert reset while core_state=UPDATE with a write pending -> every register returns to its reset value, with no write from that cycle.
